// File: rtl/minirisc_datapath.sv
// minirisc_datapath: single-cycle 32-bit KGP miniRISC datapath driven by an external control unit
module minirisc_datapath #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter string IMEM_INIT = "imem.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        ImmSel,
  input  logic        ALUSrc,
  input  logic        CompEnbl,
  input  logic        ShiftAmntSel,
  input  logic        ShiftEnbl,
  input  logic        ShortBr,
  input  logic        LongBr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        BranchReg,
  input  logic [1:0]  ALUOp,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  ShiftType,
  input  logic [1:0]  BranchType,
  input  logic [1:0]  JumpType,
  input  logic [1:0]  MemToReg,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [31:0] r4,
  output logic [31:0] r5,
  output logic [31:0] r31,
  output logic [31:0] PC_OUT
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH] = '{default: '0};
  logic [31:0] regs [32];
  logic [31:0] pc, instr, op1, op2, rt_val, imm, alu_out, sh_out, res, wdata, pc_inc, pc_next, rd_data;
  logic [32:0] sum;
  logic [4:0] rs, rt, amt, dst;
  logic [DAW-1:0] daddr;
  logic [5:0] unused_opcode;
  logic carry, short_tk, long_tk;
  assign instr = imem[IAW'(pc % 32'(IMEM_DEPTH))];
  assign unused_opcode = instr[31:26];
  always_comb begin
    rs = instr[25:21];
    rt = instr[20:16];
    op1 = regs[rs];
    rt_val = regs[rt];
    imm = ImmSel ? {{16{instr[15]}}, instr[15:0]} : {{11{instr[20]}}, instr[20:0]};
    op2 = ALUSrc ? imm : rt_val;
    sum = {1'b0, op1} + {1'b0, op2};
    alu_out = CompEnbl ? ~op2 + 32'd1 : ALUOp == 2'b00 ? op2 : ALUOp == 2'b01 ? sum[31:0] : ALUOp == 2'b10 ? op1 & op2 : op1 ^ op2;
    amt = ShiftAmntSel ? rt_val[4:0] : instr[15:11];
    sh_out = ShiftType == 2'b01 ? op1 >> amt : ShiftType == 2'b10 ? $unsigned($signed(op1) >>> amt) : op1 << amt;
    res = ShiftEnbl ? sh_out : alu_out;
    daddr = DAW'(alu_out % 32'(DMEM_DEPTH));
    rd_data = MemRead ? dmem[daddr] : '0;
    pc_inc = pc + 32'd1;
    wdata = MemToReg == 2'b01 ? rd_data : MemToReg == 2'b10 ? pc_inc : MemToReg == 2'b11 ? alu_out : res;
    dst = RegDst == 2'b01 ? rt : RegDst == 2'b10 ? 5'd31 : rs;
    short_tk = ShortBr && (BranchType == 2'b00 ? op1[31] : BranchType == 2'b01 ? op1 == '0 : BranchType == 2'b10 ? op1 != '0 : 1'b0);
    long_tk = LongBr && (JumpType == 2'b00 || (JumpType == 2'b01 && carry) || (JumpType == 2'b10 && !carry));
    pc_next = BranchReg ? op1 : long_tk ? pc_inc + {{6{instr[25]}}, instr[25:0]} : short_tk ? pc_inc + {{11{instr[20]}}, instr[20:0]} : pc_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      carry <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (RegWrite) regs[dst] <= wdata;
      if (RegWrite && ALUOp == 2'b01 && !CompEnbl) carry <= sum[32];
    end
  end
  always_ff @(posedge clk) begin
    if (MemWrite && !rst) dmem[daddr] <= rt_val;
  end
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r31 = regs[31];
  assign PC_OUT = pc;
endmodule

// File: tb/tb_minirisc_datapath.sv
// tb_minirisc_datapath: directed program exercising ALU, memory, branches, shifts and reset
module tb_minirisc_datapath;
  typedef struct packed {
    logic rw, imm_sel, alu_src, comp, sh_sel, sh_en, short_br, long_br, mem_rd, mem_wr, br_reg;
    logic [1:0] alu_op, reg_dst, sh_type, br_type, j_type, m2r;
  } ctrl_t;
  localparam ctrl_t NOP   = '0;
  localparam ctrl_t ADDI  = '{rw: 1'b1, alu_src: 1'b1, alu_op: 2'b01, default: '0};
  localparam ctrl_t COMPI = '{rw: 1'b1, alu_src: 1'b1, comp: 1'b1, default: '0};
  localparam ctrl_t ADD   = '{rw: 1'b1, alu_op: 2'b01, default: '0};
  localparam ctrl_t COMP  = '{rw: 1'b1, comp: 1'b1, default: '0};
  localparam ctrl_t AND   = '{rw: 1'b1, alu_op: 2'b10, default: '0};
  localparam ctrl_t XOR   = '{rw: 1'b1, alu_op: 2'b11, default: '0};
  localparam ctrl_t LW    = '{rw: 1'b1, imm_sel: 1'b1, alu_src: 1'b1, alu_op: 2'b01, mem_rd: 1'b1, reg_dst: 2'b01, m2r: 2'b01, default: '0};
  localparam ctrl_t SW    = '{imm_sel: 1'b1, alu_src: 1'b1, alu_op: 2'b01, mem_wr: 1'b1, default: '0};
  localparam ctrl_t BL    = '{rw: 1'b1, long_br: 1'b1, j_type: 2'b00, reg_dst: 2'b10, m2r: 2'b10, default: '0};
  localparam ctrl_t BCY   = '{long_br: 1'b1, j_type: 2'b01, default: '0};
  localparam ctrl_t BNCY  = '{long_br: 1'b1, j_type: 2'b10, default: '0};
  localparam ctrl_t BLTZ  = '{short_br: 1'b1, br_type: 2'b00, default: '0};
  localparam ctrl_t BZ    = '{short_br: 1'b1, br_type: 2'b01, default: '0};
  localparam ctrl_t BNZ   = '{short_br: 1'b1, br_type: 2'b10, default: '0};
  localparam ctrl_t SHL   = '{rw: 1'b1, sh_en: 1'b1, sh_type: 2'b00, default: '0};
  localparam ctrl_t SHRA  = '{rw: 1'b1, sh_en: 1'b1, sh_type: 2'b10, default: '0};
  localparam ctrl_t SHRLV = '{rw: 1'b1, sh_en: 1'b1, sh_sel: 1'b1, sh_type: 2'b01, default: '0};
  localparam ctrl_t BR    = '{br_reg: 1'b1, default: '0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  ctrl_t ctl = '0;
  logic [31:0] r0, r1, r2, r3, r4, r5, r31, pc_out;
  int errors = 0;
  int checks = 0;
  minirisc_datapath #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .IMEM_INIT("")) dut (
    .clk(clk), .rst(rst), .RegWrite(ctl.rw), .ImmSel(ctl.imm_sel), .ALUSrc(ctl.alu_src),
    .CompEnbl(ctl.comp), .ShiftAmntSel(ctl.sh_sel), .ShiftEnbl(ctl.sh_en), .ShortBr(ctl.short_br),
    .LongBr(ctl.long_br), .MemRead(ctl.mem_rd), .MemWrite(ctl.mem_wr), .BranchReg(ctl.br_reg),
    .ALUOp(ctl.alu_op), .RegDst(ctl.reg_dst), .ShiftType(ctl.sh_type), .BranchType(ctl.br_type),
    .JumpType(ctl.j_type), .MemToReg(ctl.m2r), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .r5(r5), .r31(r31), .PC_OUT(pc_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ri(input logic [4:0] s, input int i);
    return {6'd0, s, 21'(i)};
  endfunction
  function automatic logic [31:0] rr(input logic [4:0] s, input logic [4:0] t, input logic [4:0] sh);
    return {6'd0, s, t, sh, 11'd0};
  endfunction
  function automatic logic [31:0] mi(input logic [4:0] s, input logic [4:0] t, input int i);
    return {6'd0, s, t, 16'(i)};
  endfunction
  function automatic logic [31:0] lj(input int i);
    return {6'd0, 26'(i)};
  endfunction
  task automatic exec(input logic [31:0] ins, input ctrl_t c);
    dut.imem[pc_out[9:0]] = ins;
    ctl = c;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    ctl = NOP;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'd0); end
    checks++; if (r0 !== 32'd0) begin errors++; $display("FAIL reset_r0: got %h want %h", r0, 32'd0); end
    checks++; if (r1 !== 32'd0) begin errors++; $display("FAIL reset_r1: got %h want %h", r1, 32'd0); end
    checks++; if (r2 !== 32'd0) begin errors++; $display("FAIL reset_r2: got %h want %h", r2, 32'd0); end
    checks++; if (r3 !== 32'd0) begin errors++; $display("FAIL reset_r3: got %h want %h", r3, 32'd0); end
    checks++; if (r4 !== 32'd0) begin errors++; $display("FAIL reset_r4: got %h want %h", r4, 32'd0); end
    checks++; if (r5 !== 32'd0) begin errors++; $display("FAIL reset_r5: got %h want %h", r5, 32'd0); end
    checks++; if (r31 !== 32'd0) begin errors++; $display("FAIL reset_r31: got %h want %h", r31, 32'd0); end
    rst = 1'b0;
  endtask
  task automatic test_addi;
    exec(ri(0, 5), ADDI);
    exec(ri(1, 69), ADDI);
    exec(ri(4, 3), ADDI);
    checks++; if (r0 !== 32'd5) begin errors++; $display("FAIL addi_r0: got %h want %h", r0, 32'd5); end
    checks++; if (r1 !== 32'd69) begin errors++; $display("FAIL addi_r1: got %h want %h", r1, 32'd69); end
    checks++; if (r4 !== 32'd3) begin errors++; $display("FAIL addi_r4: got %h want %h", r4, 32'd3); end
    checks++; if (pc_out !== 32'd3) begin errors++; $display("FAIL addi_pc: got %h want %h", pc_out, 32'd3); end
  endtask
  task automatic test_comp_add;
    exec(ri(0, 7), COMPI);
    exec(ri(2, -26), ADDI);
    exec(rr(4, 2, 0), ADD);
    exec(rr(3, 4, 0), COMP);
    checks++; if (r0 !== 32'(-7)) begin errors++; $display("FAIL compi_r0: got %h want %h", r0, 32'(-7)); end
    checks++; if (r2 !== 32'(-26)) begin errors++; $display("FAIL addi_neg_r2: got %h want %h", r2, 32'(-26)); end
    checks++; if (r4 !== 32'(-23)) begin errors++; $display("FAIL add_r4: got %h want %h", r4, 32'(-23)); end
    checks++; if (r3 !== 32'd23) begin errors++; $display("FAIL comp_r3: got %h want %h", r3, 32'd23); end
  endtask
  task automatic test_logic;
    exec(rr(1, 3, 0), AND);
    checks++; if (r1 !== 32'd5) begin errors++; $display("FAIL and_r1: got %h want %h", r1, 32'd5); end
    exec(rr(0, 1, 0), XOR);
    checks++; if (r0 !== 32'(-4)) begin errors++; $display("FAIL xor_r0: got %h want %h", r0, 32'(-4)); end
    exec(ri(0, 2), ADDI);
    exec(rr(2, 4, 0), ADD);
    checks++; if (r0 !== 32'(-2)) begin errors++; $display("FAIL addi_r0b: got %h want %h", r0, 32'(-2)); end
    checks++; if (r2 !== 32'(-49)) begin errors++; $display("FAIL add_r2: got %h want %h", r2, 32'(-49)); end
  endtask
  task automatic test_compi;
    exec(ri(0, 1), COMPI);
    checks++; if (r0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL compi1_r0: got %h want %h", r0, 32'hFFFF_FFFF); end
    exec(ri(1, -4), ADDI);
    exec(ri(0, -10), COMPI);
    checks++; if (r0 !== 32'd10) begin errors++; $display("FAIL compi_neg_r0: got %h want %h", r0, 32'd10); end
    checks++; if (r1 !== 32'd1) begin errors++; $display("FAIL addi_wrap_r1: got %h want %h", r1, 32'd1); end
  endtask
  task automatic test_mem;
    exec(mi(1, 3, -1), LW);
    checks++; if (r3 !== 32'd0) begin errors++; $display("FAIL lw_zero_r3: got %h want %h", r3, 32'd0); end
    exec(ri(3, 51), ADDI);
    checks++; if (r3 !== 32'd51) begin errors++; $display("FAIL addi_r3: got %h want %h", r3, 32'd51); end
    exec(mi(2, 3, 49), SW);
    exec(mi(4, 5, 23), LW);
    checks++; if (r5 !== 32'd51) begin errors++; $display("FAIL sw_lw_r5: got %h want %h", r5, 32'd51); end
    checks++; if (pc_out !== 32'd18) begin errors++; $display("FAIL mem_pc: got %h want %h", pc_out, 32'd18); end
  endtask
  task automatic test_carry_branch;
    exec(lj(2), BCY);
    checks++; if (pc_out !== 32'd21) begin errors++; $display("FAIL bcy_taken_pc: got %h want %h", pc_out, 32'd21); end
    exec(lj(5), BNCY);
    checks++; if (pc_out !== 32'd22) begin errors++; $display("FAIL bncy_not_taken_pc: got %h want %h", pc_out, 32'd22); end
  endtask
  task automatic test_bl;
    exec(lj(4), BL);
    checks++; if (r31 !== 32'd23) begin errors++; $display("FAIL bl_r31: got %h want %h", r31, 32'd23); end
    checks++; if (pc_out !== 32'd27) begin errors++; $display("FAIL bl_pc: got %h want %h", pc_out, 32'd27); end
  endtask
  task automatic test_short_branch;
    exec(ri(1, -1), ADDI);
    checks++; if (r1 !== 32'd0) begin errors++; $display("FAIL zero_r1: got %h want %h", r1, 32'd0); end
    exec(ri(1, 3), BZ);
    checks++; if (pc_out !== 32'd32) begin errors++; $display("FAIL bz_taken_pc: got %h want %h", pc_out, 32'd32); end
    exec(ri(1, 3), BNZ);
    checks++; if (pc_out !== 32'd33) begin errors++; $display("FAIL bnz_not_taken_pc: got %h want %h", pc_out, 32'd33); end
    exec(ri(0, 2), BNZ);
    checks++; if (pc_out !== 32'd36) begin errors++; $display("FAIL bnz_taken_pc: got %h want %h", pc_out, 32'd36); end
    exec(ri(2, -5), BLTZ);
    checks++; if (pc_out !== 32'd32) begin errors++; $display("FAIL bltz_back_pc: got %h want %h", pc_out, 32'd32); end
  endtask
  task automatic test_shift;
    exec(ri(1, 1), ADDI);
    exec(rr(1, 0, 31), SHL);
    checks++; if (r1 !== 32'h8000_0000) begin errors++; $display("FAIL sll_r1: got %h want %h", r1, 32'h8000_0000); end
    exec(rr(1, 0, 4), SHRA);
    checks++; if (r1 !== 32'hF800_0000) begin errors++; $display("FAIL shra_r1: got %h want %h", r1, 32'hF800_0000); end
    exec(rr(1, 4, 0), SHRLV);
    checks++; if (r1 !== 32'h007C_0000) begin errors++; $display("FAIL srlv_r1: got %h want %h", r1, 32'h007C_0000); end
    checks++; if (pc_out !== 32'd36) begin errors++; $display("FAIL shift_pc: got %h want %h", pc_out, 32'd36); end
  endtask
  task automatic test_branch_reg;
    exec(rr(3, 0, 0), BR);
    checks++; if (pc_out !== 32'd51) begin errors++; $display("FAIL br_reg_pc: got %h want %h", pc_out, 32'd51); end
  endtask
  task automatic test_reset_mid;
    rst = 1'b1;
    ctl = ADDI;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ctl = NOP;
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL mid_reset_pc: got %h want %h", pc_out, 32'd0); end
    checks++; if (r0 !== 32'd0) begin errors++; $display("FAIL mid_reset_r0: got %h want %h", r0, 32'd0); end
    checks++; if (r3 !== 32'd0) begin errors++; $display("FAIL mid_reset_r3: got %h want %h", r3, 32'd0); end
    checks++; if (r31 !== 32'd0) begin errors++; $display("FAIL mid_reset_r31: got %h want %h", r31, 32'd0); end
  endtask
  initial begin
    test_reset;
    test_addi;
    test_comp_add;
    test_logic;
    test_compi;
    test_mem;
    test_carry_branch;
    test_bl;
    test_short_branch;
    test_shift;
    test_branch_reg;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
